// File: rtl/l1_write_buffer.sv
`default_nettype none
// ============================================================================
// Module  : l1_write_buffer
// Brief   : Posted write buffer between L1 D-cache and memory; forwards fill
//           reads from buffered writes. Optional macro: WB_COALESCE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module l1_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_request,
    input  logic                         mem_write_enable,
    input  logic [ADDR_WIDTH-1:0]        mem_address,
    input  logic [DATA_WIDTH-1:0]        mem_write_data,
    output logic [DATA_WIDTH-1:0]        mem_response_data,
    output logic                         mem_ready,
    output logic                         bus_request,
    output logic                         bus_write_enable,
    output logic [ADDR_WIDTH-1:0]        bus_address,
    output logic [DATA_WIDTH-1:0]        bus_write_data,
    input  logic [DATA_WIDTH-1:0]        bus_response_data,
    input  logic                         bus_ready,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {U_IDLE = 2'd0, U_WAIT_RD = 2'd1, U_ACK = 2'd2} u_state_t;
    typedef enum logic [1:0] {B_IDLE = 2'd0, B_WRITE = 2'd1, B_READ = 2'd2} b_state_t;

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [c_PTR_W-1:0]    r_head, r_tail;
    logic [c_CNT_W-1:0]    r_count, w_count_n;
    logic                  r_empty;
    logic                  r_rd_pending;

    u_state_t              r_u_state, w_u_next;
    b_state_t              r_b_state, w_b_next;
    logic                  r_mem_ready, w_mem_ready_n;
    logic [DATA_WIDTH-1:0] r_resp, w_resp_n;
    logic                  r_bus_req, w_bus_req_n;
    logic                  r_bus_we, w_bus_we_n;
    logic [ADDR_WIDTH-1:0] r_bus_addr, w_bus_addr_n;
    logic [DATA_WIDTH-1:0] r_bus_wdata, w_bus_wdata_n;

    logic                  w_push, w_pop, w_coal, w_full;
    logic                  w_rd_set, w_rd_done;
    logic                  w_hit, w_coal_hit;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic [c_PTR_W-1:0]    w_slot [DEPTH];

    // w_slot[k] is the k-th oldest slot; later matches in a scan are newer
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_slot
            assign w_slot[k] = r_head + c_PTR_W'(k);
        end
    endgenerate

    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[w_slot[k]] &&
                r_addr[w_slot[k]][ADDR_WIDTH-1:2] == mem_address[ADDR_WIDTH-1:2]) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_slot[k]];
            end
        end
    end

`ifdef WB_COALESCE_EN
    logic [c_PTR_W-1:0] w_coal_idx;
    logic               w_head_busy;

    // Head is off-limits once its drain has launched or launches this edge
    assign w_head_busy = (r_b_state == B_WRITE) ||
                         (r_b_state == B_IDLE && !r_rd_pending && r_count != '0);

    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[w_slot[k]] && !(k == 0 && w_head_busy) &&
                r_addr[w_slot[k]][ADDR_WIDTH-1:2] == mem_address[ADDR_WIDTH-1:2]) begin
                w_coal_hit = 1'b1;
                w_coal_idx = w_slot[k];
            end
        end
    end
`else
    assign w_coal_hit = 1'b0;
`endif

    // A pop in the same cycle frees a slot for a push
    assign w_full = (r_count == c_FULL) && !w_pop;

    always_comb begin
        w_u_next      = r_u_state;
        w_mem_ready_n = 1'b0;
        w_resp_n      = r_resp;
        w_push        = 1'b0;
        w_coal        = 1'b0;
        w_rd_set      = 1'b0;
        case (r_u_state)
            U_IDLE: begin
                if (mem_request) begin
                    if (mem_write_enable) begin
                        if (w_coal_hit) begin
                            w_coal        = 1'b1;
                            w_mem_ready_n = 1'b1;
                            w_u_next      = U_ACK;
                        end else if (!w_full) begin
                            w_push        = 1'b1;
                            w_mem_ready_n = 1'b1;
                            w_u_next      = U_ACK;
                        end
                    end else if (w_hit) begin
                        w_resp_n      = w_hit_data;
                        w_mem_ready_n = 1'b1;
                        w_u_next      = U_ACK;
                    end else begin
                        w_rd_set = 1'b1;
                        w_u_next = U_WAIT_RD;
                    end
                end
            end
            U_WAIT_RD: begin
                if (w_rd_done) begin
                    w_resp_n      = bus_response_data;
                    w_mem_ready_n = 1'b1;
                    w_u_next      = U_ACK;
                end
            end
            U_ACK:   w_u_next = U_IDLE;
            default: w_u_next = U_IDLE;
        endcase
    end

    always_comb begin
        w_b_next      = r_b_state;
        w_bus_req_n   = r_bus_req;
        w_bus_we_n    = r_bus_we;
        w_bus_addr_n  = r_bus_addr;
        w_bus_wdata_n = r_bus_wdata;
        w_pop         = 1'b0;
        w_rd_done     = 1'b0;
        case (r_b_state)
            B_IDLE: begin
                if (r_rd_pending) begin
                    w_bus_req_n  = 1'b1;
                    w_bus_we_n   = 1'b0;
                    w_bus_addr_n = mem_address;
                    w_b_next     = B_READ;
                end else if (r_count != '0) begin
                    w_bus_req_n   = 1'b1;
                    w_bus_we_n    = 1'b1;
                    w_bus_addr_n  = r_addr[r_head];
                    w_bus_wdata_n = r_data[r_head];
                    w_b_next      = B_WRITE;
                end
            end
            B_WRITE: begin
                if (bus_ready) begin
                    w_pop       = 1'b1;
                    w_bus_req_n = 1'b0;
                    w_b_next    = B_IDLE;
                end
            end
            B_READ: begin
                if (bus_ready) begin
                    w_rd_done   = 1'b1;
                    w_bus_req_n = 1'b0;
                    w_b_next    = B_IDLE;
                end
            end
            default: w_b_next = B_IDLE;
        endcase
    end

    always_comb begin
        w_count_n = r_count;
        if (w_push && !w_pop)      w_count_n = r_count + c_CNT_W'(1);
        else if (w_pop && !w_push) w_count_n = r_count - c_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= mem_address;
            r_data[r_tail] <= mem_write_data;
        end
`ifdef WB_COALESCE_EN
        if (w_coal) r_data[w_coal_idx] <= mem_write_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_rd_pending <= 1'b0;
        end else begin
            // Push after pop so a full-buffer push into the freed slot wins
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
            r_count <= w_count_n;
            r_empty <= (w_count_n == '0);
            if (w_rd_set)       r_rd_pending <= 1'b1;
            else if (w_rd_done) r_rd_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_u_state   <= U_IDLE;
            r_mem_ready <= 1'b0;
            r_resp      <= '0;
            r_b_state   <= B_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_u_state   <= w_u_next;
            r_mem_ready <= w_mem_ready_n;
            r_resp      <= w_resp_n;
            r_b_state   <= w_b_next;
            r_bus_req   <= w_bus_req_n;
            r_bus_we    <= w_bus_we_n;
            r_bus_addr  <= w_bus_addr_n;
            r_bus_wdata <= w_bus_wdata_n;
        end
    end

    assign mem_ready         = r_mem_ready;
    assign mem_response_data = r_resp;
    assign bus_request       = r_bus_req;
    assign bus_write_enable  = r_bus_we;
    assign bus_address       = r_bus_addr;
    assign bus_write_data    = r_bus_wdata;
    assign empty             = r_empty;
    assign count             = r_count;

endmodule
`default_nettype wire

// File: tb/tb_l1_write_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_l1_write_buffer
// Brief   : Directed self-checking bench for l1_write_buffer (DEPTH = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_l1_write_buffer;
    localparam int c_DEPTH = 4;
    localparam int c_AW    = 32;
    localparam int c_DW    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_request, mem_write_enable;
    logic [c_AW-1:0]   mem_address;
    logic [c_DW-1:0]   mem_write_data, mem_response_data;
    logic              mem_ready;
    logic              bus_request, bus_write_enable;
    logic [c_AW-1:0]   bus_address;
    logic [c_DW-1:0]   bus_write_data, bus_response_data;
    logic              bus_ready;
    logic              empty;
    logic [$clog2(c_DEPTH+1)-1:0] count;

    int n_total = 0;
    int n_bad   = 0;

    l1_write_buffer #(.DEPTH(c_DEPTH), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_request       (mem_request),
        .mem_write_enable  (mem_write_enable),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_response_data (mem_response_data),
        .mem_ready         (mem_ready),
        .bus_request       (bus_request),
        .bus_write_enable  (bus_write_enable),
        .bus_address       (bus_address),
        .bus_write_data    (bus_write_data),
        .bus_response_data (bus_response_data),
        .bus_ready         (bus_ready),
        .empty             (empty),
        .count             (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
        mem_request      = 1'b1;
        mem_write_enable = 1'b1;
        mem_address      = a;
        mem_write_data   = d;
        step();
        chk({tag, "_ack"}, mem_ready, 1);
        mem_request = 1'b0;
        step();
    endtask

    task automatic drain_one(input logic [31:0] a, input logic [31:0] d, input string tag);
        int n = 0;
        while (bus_request !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"},  bus_request, 1);
        chk({tag, "_we"},   bus_write_enable, 1);
        chk({tag, "_addr"}, bus_address, a);
        chk({tag, "_data"}, bus_write_data, d);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_request = 1'b0; mem_write_enable = 1'b0;
        mem_address = '0; mem_write_data = '0;
        bus_response_data = '0; bus_ready = 1'b0;
        repeat (3) step();
        chk("rst_ready", mem_ready, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_breq",  bus_request, 0);
        chk("rst_bwe",   bus_write_enable, 0);
        chk("rst_baddr", bus_address, 0);
        chk("rst_resp",  mem_response_data, 0);
        rst = 1'b0;
        step();

        // Single write, held drain, then completion
        mem_request = 1'b1; mem_write_enable = 1'b1;
        mem_address = 32'h100; mem_write_data = 32'hDEADBEEF;
        step();
        chk("w1_ack",   mem_ready, 1);
        chk("w1_count", count, 1);
        chk("w1_empty", empty, 0);
        mem_request = 1'b0;
        step();
        chk("w1_ackdrop", mem_ready, 0);
        chk("w1_breq",    bus_request, 1);
        chk("w1_baddr",   bus_address, 32'h100);
        chk("w1_bwe",     bus_write_enable, 1);
        chk("w1_bdata",   bus_write_data, 32'hDEADBEEF);
        repeat (2) step();
        chk("w1_hold", bus_request, 1);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("w1_popcnt", count, 0);
        chk("w1_empty2", empty, 1);
        chk("w1_breq0",  bus_request, 0);

        // Forwarding hit before drain completes
        wr(32'h200, 32'h11, "fw_wr");
        mem_request = 1'b1; mem_write_enable = 1'b0; mem_address = 32'h200;
        step();
        chk("fw_ready", mem_ready, 1);
        chk("fw_data",  mem_response_data, 32'h11);
        chk("fw_buswr", bus_write_enable, 1);
        mem_request = 1'b0;
        step();
        drain_one(32'h200, 32'h11, "fw_dr");
        chk("fw_count", count, 0);

        // Fill to DEPTH, fifth write stalls until a pop frees a slot
        for (int i = 0; i < 4; i++)
            wr(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), "full_wr");
        chk("full_cnt4", count, 4);
        mem_request = 1'b1; mem_write_enable = 1'b1;
        mem_address = 32'h1010; mem_write_data = 32'hA4;
        step();
        chk("full_hold1", mem_ready, 0);
        step();
        chk("full_hold2", mem_ready, 0);
        chk("full_cnt",   count, 4);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("full_ack",    mem_ready, 1);
        chk("full_cntpp",  count, 4);
        mem_request = 1'b0;
        step();
        for (int i = 1; i < 5; i++)
            drain_one(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), "full_dr");
        chk("full_cnt0", count, 0);

        // Read miss serviced from memory
        mem_request = 1'b1; mem_write_enable = 1'b0; mem_address = 32'h300;
        step();
        chk("rm_noack", mem_ready, 0);
        step();
        chk("rm_breq",  bus_request, 1);
        chk("rm_bwe",   bus_write_enable, 0);
        chk("rm_baddr", bus_address, 32'h300);
        repeat (2) step();
        bus_ready = 1'b1; bus_response_data = 32'hCAFE;
        step();
        bus_ready = 1'b0; bus_response_data = '0; mem_request = 1'b0;
        chk("rm_ready", mem_ready, 1);
        chk("rm_data",  mem_response_data, 32'hCAFE);
        chk("rm_breq0", bus_request, 0);
        step();
        chk("rm_drop", mem_ready, 0);

        // Same-address writes while a different head drains
        wr(32'h500, 32'h7, "co_head");
        wr(32'h400, 32'h1, "co_w1");
        wr(32'h400, 32'h2, "co_w2");
`ifdef WB_COALESCE_EN
        chk("co_count", count, 2);
`else
        chk("co_count", count, 3);
`endif
        mem_request = 1'b1; mem_write_enable = 1'b0; mem_address = 32'h400;
        step();
        chk("co_rdy",  mem_ready, 1);
        chk("co_rd",   mem_response_data, 32'h2);
        mem_request = 1'b0;
        step();
        drain_one(32'h500, 32'h7, "co_d0");
`ifndef WB_COALESCE_EN
        drain_one(32'h400, 32'h1, "co_d1");
`endif
        drain_one(32'h400, 32'h2, "co_d2");
        chk("co_cnt0", count, 0);

        // Reset while draining with three entries buffered
        wr(32'h600, 32'h60, "rs_w0");
        wr(32'h604, 32'h61, "rs_w1");
        wr(32'h608, 32'h62, "rs_w2");
        chk("rs_cnt3", count, 3);
        chk("rs_busy", bus_request, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_breq",  bus_request, 0);
        chk("rs_count", count, 0);
        chk("rs_empty", empty, 1);
        chk("rs_ready", mem_ready, 0);
        wr(32'h700, 32'h70, "rs_post");
        drain_one(32'h700, 32'h70, "rs_dr");
        chk("rs_cnt0", count, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
